// File: rtl/cpu_pkg.sv
// Shared CPU package: pipeline constants plus the memory-arbiter width and
// state encodings used by mem_arbiter and mem_lane.
package cpu_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      WIDTH_BYTE = 2'b00,
      WIDTH_HALF = 2'b01,
      WIDTH_WORD = 2'b10
   } mem_width_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_BUSY_FE  = 2'b01,
      ST_BUSY_MEM = 2'b10
   } arb_state_e;

   // Width code 2'b11 falls into the word branch.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (width)
         WIDTH_BYTE: bad = 1'b0;
         WIDTH_HALF: bad = lo[0];
         default:    bad = (lo != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: byte enables and replicated store data on the way out,
// lane extraction plus sign/zero extension on the way back.
module mem_lane
   import cpu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  width,
   input  logic        extend,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   assign shifted = load_word >> {addr_lo, 3'b000};

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      be        = 4'b1111;
      wdata     = store_data;
      load_data = shifted;
      case (width)
         WIDTH_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{extend & shifted[7]}}, shifted[7:0]};
         end
         WIDTH_HALF: begin
            be        = 4'b0011 << addr_lo;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{extend & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory bus between instruction
// fetch and load/store, with lane steering and misalignment rejection.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter bit MEM_FIRST = 1'b1
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fe_req,
   input  logic [31:0] fe_addr,
   output logic        fe_ack,
   output logic [31:0] fe_data,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_write,
   input  logic [31:0] mem_data_in,
   input  logic        mem_extend,
   input  logic [1:0]  mem_width,
   output logic        mem_ack,
   output logic [31:0] mem_data_out,
   output logic        mem_misalign,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic        bus_write,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   arb_state_e  state, state_nxt;
   logic        last_fe, last_fe_nxt;
   logic [1:0]  acc_lo, acc_lo_nxt;
   logic [1:0]  acc_width, acc_width_nxt;
   logic        acc_extend, acc_extend_nxt;

   logic        fe_ack_nxt, mem_ack_nxt, mem_misalign_nxt;
   logic [31:0] fe_data_nxt, mem_data_out_nxt;
   logic        bus_req_nxt, bus_write_nxt;
   logic [31:0] bus_addr_nxt, bus_wdata_nxt;
   logic [3:0]  bus_be_nxt;
   logic        grant_fe, grant_mem;

   logic [1:0]  lane_lo, lane_width;
   logic        lane_extend;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, lane_load;

   // While busy the requester may already have dropped its inputs, so the
   // load path uses the attributes captured at grant time.
   assign lane_lo     = (state == ST_IDLE) ? mem_addr[1:0] : acc_lo;
   assign lane_width  = (state == ST_IDLE) ? mem_width     : acc_width;
   assign lane_extend = (state == ST_IDLE) ? mem_extend    : acc_extend;

   mem_lane u_lane (
      .addr_lo    (lane_lo),
      .width      (lane_width),
      .extend     (lane_extend),
      .store_data (mem_data_in),
      .load_word  (bus_rdata),
      .be         (lane_be),
      .wdata      (lane_wdata),
      .load_data  (lane_load)
   );

   always_comb begin
      state_nxt        = state;
      last_fe_nxt      = last_fe;
      acc_lo_nxt       = acc_lo;
      acc_width_nxt    = acc_width;
      acc_extend_nxt   = acc_extend;
      bus_req_nxt      = bus_req;
      bus_addr_nxt     = bus_addr;
      bus_write_nxt    = bus_write;
      bus_be_nxt       = bus_be;
      bus_wdata_nxt    = bus_wdata;
      fe_ack_nxt       = 1'b0;
      fe_data_nxt      = '0;
      mem_ack_nxt      = 1'b0;
      mem_data_out_nxt = '0;
      mem_misalign_nxt = 1'b0;
      grant_fe         = 1'b0;
      grant_mem        = 1'b0;

      unique case (state)
         ST_IDLE: begin
            // An ack still pulsing blocks arbitration so the requester can drop its request.
            if (!fe_ack && !mem_ack) begin
               if (fe_req && mem_req) begin
                  grant_mem = last_fe;
                  grant_fe  = !last_fe;
               end else begin
                  grant_fe  = fe_req;
                  grant_mem = mem_req;
               end
            end
            if (grant_fe) begin
               last_fe_nxt   = 1'b1;
               bus_req_nxt   = 1'b1;
               bus_addr_nxt  = fe_addr & ~32'h3;
               bus_write_nxt = 1'b0;
               bus_be_nxt    = 4'b1111;
               bus_wdata_nxt = '0;
               state_nxt     = ST_BUSY_FE;
            end else if (grant_mem) begin
               last_fe_nxt = 1'b0;
               if (is_misaligned(mem_width, mem_addr[1:0])) begin
                  mem_ack_nxt      = 1'b1;
                  mem_misalign_nxt = 1'b1;
               end else begin
                  bus_req_nxt    = 1'b1;
                  bus_addr_nxt   = mem_addr & ~32'h3;
                  bus_write_nxt  = mem_write;
                  bus_be_nxt     = lane_be;
                  bus_wdata_nxt  = mem_write ? lane_wdata : '0;
                  acc_lo_nxt     = mem_addr[1:0];
                  acc_width_nxt  = mem_width;
                  acc_extend_nxt = mem_extend;
                  state_nxt      = ST_BUSY_MEM;
               end
            end
         end
         ST_BUSY_FE: begin
            if (bus_ack) begin
               bus_req_nxt = 1'b0;
               fe_ack_nxt  = 1'b1;
               fe_data_nxt = bus_rdata;
               state_nxt   = ST_IDLE;
            end
         end
         ST_BUSY_MEM: begin
            if (bus_ack) begin
               bus_req_nxt      = 1'b0;
               mem_ack_nxt      = 1'b1;
               mem_data_out_nxt = bus_write ? '0 : lane_load;
               state_nxt        = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         last_fe      <= MEM_FIRST;
         acc_lo       <= '0;
         acc_width    <= '0;
         acc_extend   <= 1'b0;
         bus_req      <= 1'b0;
         bus_addr     <= '0;
         bus_write    <= 1'b0;
         bus_be       <= '0;
         bus_wdata    <= '0;
         fe_ack       <= 1'b0;
         fe_data      <= '0;
         mem_ack      <= 1'b0;
         mem_data_out <= '0;
         mem_misalign <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_fe      <= last_fe_nxt;
         acc_lo       <= acc_lo_nxt;
         acc_width    <= acc_width_nxt;
         acc_extend   <= acc_extend_nxt;
         bus_req      <= bus_req_nxt;
         bus_addr     <= bus_addr_nxt;
         bus_write    <= bus_write_nxt;
         bus_be       <= bus_be_nxt;
         bus_wdata    <= bus_wdata_nxt;
         fe_ack       <= fe_ack_nxt;
         fe_data      <= fe_data_nxt;
         mem_ack      <= mem_ack_nxt;
         mem_data_out <= mem_data_out_nxt;
         mem_misalign <= mem_misalign_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a bus responder with random wait states
// and a byte-arithmetic reference model for enables, store data and loads.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fe_req;
   logic [31:0] fe_addr;
   logic        fe_ack;
   logic [31:0] fe_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [31:0] mem_data_in;
   logic        mem_extend;
   logic [1:0]  mem_width;
   logic        mem_ack;
   logic [31:0] mem_data_out;
   logic        mem_misalign;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_write;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          resp_wait = 0;
   bit          resp_enable = 1'b1;
   bit          inject_ack = 1'b0;
   logic [31:0] next_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_FIRST(1'b1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .fe_req       (fe_req),
      .fe_addr      (fe_addr),
      .fe_ack       (fe_ack),
      .fe_data      (fe_data),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_write    (mem_write),
      .mem_data_in  (mem_data_in),
      .mem_extend   (mem_extend),
      .mem_width    (mem_width),
      .mem_ack      (mem_ack),
      .mem_data_out (mem_data_out),
      .mem_misalign (mem_misalign),
      .bus_req      (bus_req),
      .bus_addr     (bus_addr),
      .bus_write    (bus_write),
      .bus_be       (bus_be),
      .bus_wdata    (bus_wdata),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model: plain byte arithmetic ----------------
   function automatic int size_of(input logic [1:0] w);
      return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] w);
      return (int'(a % 4) % size_of(w)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] w);
      logic [3:0] r;
      int lo, sz;
      lo = int'(a % 4);
      sz = size_of(w);
      r  = '0;
      for (int i = 0; i < 4; i++)
         if (i >= lo && i < lo + sz) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] w);
      logic [31:0] r;
      int sz;
      sz = size_of(w);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w,
                                             input bit ext, input logic [31:0] rd);
      longint v, span;
      int lo, sz;
      lo   = int'(a % 4);
      sz   = size_of(w);
      span = longint'(1) << (8 * sz);
      v    = longint'(rd >> (8 * lo)) % span;
      if (ext && sz < 4 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   // ---------------- bus responder ----------------
   initial begin
      bit pending;
      int cnt;
      pending   = 1'b0;
      cnt       = 0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus_ack = 1'b0;
         if (!reset_n) begin
            pending = 1'b0;
         end else if (inject_ack) begin
            bus_ack   = 1'b1;
            bus_rdata = 32'hDEAD_BEEF;
         end else if (resp_enable) begin
            if (bus_req && !pending) begin
               pending = 1'b1;
               cnt     = resp_wait;
            end
            if (pending) begin
               if (cnt == 0) begin
                  bus_ack   = 1'b1;
                  bus_rdata = next_rdata;
                  pending   = 1'b0;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // ---------------- bus stability monitor ----------------
   initial begin
      logic        prev_req;
      logic [31:0] prev_addr, prev_wdata;
      logic [4:0]  prev_ctl;
      prev_req = 1'b0;
      prev_addr = '0;
      prev_wdata = '0;
      prev_ctl = '0;
      forever begin
         @(negedge clk);
         if (reset_n && bus_req && prev_req) begin
            check("bus_addr stable", bus_addr, prev_addr);
            check("bus_ctl stable", {27'd0, bus_write, bus_be}, {27'd0, prev_ctl});
            check("bus_wdata stable", bus_wdata, prev_wdata);
         end
         prev_req   = reset_n && bus_req;
         prev_addr  = bus_addr;
         prev_wdata = bus_wdata;
         prev_ctl   = {bus_write, bus_be};
      end
   end

   // One complete access from one requester, checked against the model.
   task automatic run_access(input bit is_fe, input logic [31:0] addr, input bit wr,
                             input logic [31:0] wd, input bit ext, input logic [1:0] w,
                             input logic [31:0] rdata, input int waits, input bit drop,
                             input string tag);
      bit          saw_req, got_ack, mis;
      int          cyc;
      logic [31:0] cap_addr, cap_wdata, ack_data;
      logic [3:0]  cap_be;
      logic        cap_wr, ack_mis;
      saw_req = 1'b0; got_ack = 1'b0; cyc = 0;
      cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_wr = 1'b0;
      ack_data = '0; ack_mis = 1'b0;
      mis = !is_fe && model_misaligned(addr, w);
      @(posedge clk);
      #1;
      resp_wait  = waits;
      next_rdata = rdata;
      if (is_fe) begin
         fe_req  = 1'b1;
         fe_addr = addr;
      end else begin
         mem_req     = 1'b1;
         mem_addr    = addr;
         mem_write   = wr;
         mem_data_in = wd;
         mem_extend  = ext;
         mem_width   = w;
      end
      while (!got_ack && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus_req && !saw_req) begin
            saw_req   = 1'b1;
            cap_addr  = bus_addr;
            cap_wdata = bus_wdata;
            cap_be    = bus_be;
            cap_wr    = bus_write;
            if (drop) begin
               fe_req  = 1'b0;
               mem_req = 1'b0;
            end
         end
         if (is_fe ? fe_ack : mem_ack) begin
            got_ack  = 1'b1;
            ack_data = is_fe ? fe_data : mem_data_out;
            ack_mis  = mem_misalign;
         end
      end
      check({tag, " ack seen"}, {31'd0, got_ack}, 32'd1);
      if (mis) begin
         check({tag, " misalign bus_req"}, {31'd0, saw_req}, 32'd0);
         check({tag, " misalign flag"}, {31'd0, ack_mis}, 32'd1);
         check({tag, " misalign data"}, ack_data, 32'd0);
         check({tag, " misalign latency"}, cyc, 32'd2);
      end else begin
         check({tag, " bus_req seen"}, {31'd0, saw_req}, 32'd1);
         check({tag, " latency"}, cyc, 3 + waits);
         check({tag, " bus_addr"}, cap_addr, addr - (addr % 4));
         check({tag, " bus_be"}, {28'd0, cap_be}, {28'd0, is_fe ? 4'hF : model_be(addr, w)});
         check({tag, " bus_write"}, {31'd0, cap_wr}, {31'd0, !is_fe && wr});
         if (!is_fe && wr) check({tag, " bus_wdata"}, cap_wdata, model_wdata(wd, w));
         if (!is_fe) check({tag, " misalign low"}, {31'd0, ack_mis}, 32'd0);
         check({tag, " ack data"}, ack_data,
               is_fe ? rdata : (wr ? 32'd0 : model_load(addr, w, ext, rdata)));
      end
      @(posedge clk);
      #1;
      fe_req  = 1'b0;
      mem_req = 1'b0;
      @(negedge clk);
      check({tag, " ack one cycle"}, {31'd0, is_fe ? fe_ack : mem_ack}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " bus_req"}, {31'd0, bus_req}, 32'd0);
      check({tag, " bus_addr"}, bus_addr, 32'd0);
      check({tag, " bus_ctl"}, {27'd0, bus_write, bus_be}, 32'd0);
      check({tag, " bus_wdata"}, bus_wdata, 32'd0);
      check({tag, " acks"}, {29'd0, fe_ack, mem_ack, mem_misalign}, 32'd0);
      check({tag, " data"}, fe_data | mem_data_out, 32'd0);
   endtask

   initial begin
      bit          exp_mem_first;
      bit          got_order[$];
      logic [31:0] a, d, r;
      logic [1:0]  w;
      bit          seen;

      reset_n = 1'b0;
      fe_req = 1'b0; fe_addr = '0;
      mem_req = 1'b0; mem_addr = '0; mem_write = 1'b0;
      mem_data_in = '0; mem_extend = 1'b0; mem_width = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;

      // Both requesters held: mem wins first, then strict alternation.
      @(posedge clk);
      #1;
      resp_wait = 0; next_rdata = 32'h1111_2222;
      fe_addr = 32'h400; fe_req = 1'b1;
      mem_addr = 32'h500; mem_width = 2'b10; mem_write = 1'b0; mem_req = 1'b1;
      for (int c = 0; c < 60 && got_order.size() < 4; c++) begin
         @(negedge clk);
         if (mem_ack) got_order.push_back(1'b1);
         if (fe_ack)  got_order.push_back(1'b0);
      end
      check("arb grant count", got_order.size(), 32'd4);
      exp_mem_first = 1'b1;
      for (int i = 0; i < got_order.size(); i++)
         check($sformatf("arb grant %0d is mem", i), {31'd0, got_order[i]},
               {31'd0, exp_mem_first ^ (i % 2 == 1)});
      @(posedge clk);
      #1;
      fe_req = 1'b0; mem_req = 1'b0;
      @(negedge clk);

      run_access(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 2'b10, 32'h0000_0013, 2, 1'b0, "fetch 0x100");
      run_access(1'b0, 32'h203, 1'b0, 32'h0, 1'b1, 2'b00, 32'h80FF_1234, 1, 1'b0, "lb signed");
      run_access(1'b0, 32'h203, 1'b0, 32'h0, 1'b0, 2'b00, 32'h80FF_1234, 0, 1'b0, "lb unsigned");
      run_access(1'b0, 32'h202, 1'b1, 32'h0000_BEEF, 1'b0, 2'b01, 32'h0, 1, 1'b0, "sh 0x202");
      run_access(1'b0, 32'h201, 1'b0, 32'h0, 1'b0, 2'b10, 32'h0, 0, 1'b0, "lw misaligned");
      run_access(1'b0, 32'h33E, 1'b0, 32'h0, 1'b1, 2'b01, 32'h9ABC_5678, 3, 1'b1, "lh drop");
      run_access(1'b1, 32'h17F, 1'b0, 32'h0, 1'b0, 2'b10, 32'hCAFE_F00D, 1, 1'b1, "fetch drop");

      for (int k = 0; k < 80; k++) begin
         a = $urandom;
         d = $urandom;
         r = $urandom;
         w = 2'($urandom_range(0, 3));
         run_access($urandom_range(0, 3) == 0, a, 1'($urandom_range(0, 1)), d,
                    1'($urandom_range(0, 1)), w, r, $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $sformatf("rnd%0d", k));
      end

      // Reset while a data access is outstanding on the bus.
      resp_enable = 1'b0;
      @(posedge clk);
      #1;
      mem_addr = 32'h300; mem_width = 2'b10; mem_write = 1'b0; mem_req = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = bus_req;
      end
      check("busy_mem bus_req up", {31'd0, seen}, 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      mem_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      resp_enable = 1'b1;
      @(posedge clk);
      #2;
      inject_ack = 1'b1;
      @(posedge clk);
      #2;
      inject_ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("stale ack ignored %0d", c), {30'd0, fe_ack, mem_ack}, 32'd0);
         check($sformatf("stale ack no bus_req %0d", c), {31'd0, bus_req}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
